// File: rtl/display_phase_sequencer.sv
// Frame-phase sequencer: walks the enabled render phases in index order via an
// enable/done handshake, with skip mask, continuous mode, per-stage timeout and frame counter.
module display_phase_sequencer #(
  parameter int unsigned NUM_STAGES     = 3,
  parameter int unsigned TIMEOUT_W      = 24,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned FRAME_CNT_W    = 16,
  localparam int unsigned AW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   continuous,
  input  logic [NUM_STAGES-1:0]  stage_mask,
  input  logic [NUM_STAGES-1:0]  stage_done,
  input  logic                   err_clear,
  output logic [NUM_STAGES-1:0]  stage_enable,
  output logic [AW-1:0]          active_stage,
  output logic                   busy,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_NEXT, S_END} state_t;

  localparam logic [TIMEOUT_W-1:0] TLIM =
    TIMEOUT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t                 state, state_d;
  logic [NUM_STAGES-1:0]  mask_q, mask_d, stage_enable_d;
  logic [AW-1:0]          active_d;
  logic                   busy_d, frame_done_d, timeout_err_d;
  logic [FRAME_CNT_W-1:0] frame_count_d;
  logic [TIMEOUT_W-1:0]   timer, timer_d;
  logic [AW:0]            found;
  logic                   launch, done_sel;

  // Lowest set bit of m at index >= lo; MSB of the result flags "found".
  function automatic logic [AW:0] first_from(input logic [NUM_STAGES-1:0] m,
                                             input int unsigned lo);
    logic [AW:0] r;
    r = '0;
    for (int unsigned i = NUM_STAGES; i > 0; i--) begin
      if (m[i-1] && (i - 1 >= lo)) r = {1'b1, AW'(i - 1)};
    end
    return r;
  endfunction

  always_comb begin
    state_d        = state;
    mask_d         = mask_q;
    active_d       = active_stage;
    stage_enable_d = stage_enable;
    timer_d        = timer;
    frame_done_d   = 1'b0;
    frame_count_d  = frame_count;
    timeout_err_d  = err_clear ? 1'b0 : timeout_err;
    found          = '0;
    launch         = 1'b0;
    // stage_enable is only non-zero in RUN, where it marks the active stage
    done_sel       = |(stage_done & stage_enable);

    case (state)
      S_IDLE: begin
        if (enable) launch = 1'b1;
      end
      S_START: begin
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
          stage_enable_d[i] = (active_stage == AW'(i));
        end
        timer_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (done_sel) begin
          stage_enable_d = '0;
          state_d        = S_NEXT;
        end else begin
          timer_d = timer + 1'b1;
          if (TIMEOUT_CYCLES != 0 && timer == TLIM) begin
            stage_enable_d = '0;
            timeout_err_d  = 1'b1;
            state_d        = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        found = first_from(mask_q, 32'(active_stage) + 32'd1);
        if (found[AW]) begin
          active_d = found[AW-1:0];
          state_d  = S_START;
        end else begin
          state_d = S_END;
        end
      end
      S_END: begin
        frame_done_d  = 1'b1;
        frame_count_d = frame_count + 1'b1;
        state_d       = S_IDLE;
        if (continuous && enable) launch = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Frame start is shared by IDLE and by a continuous restart out of END.
    if (launch) begin
      mask_d = stage_mask;
      found  = first_from(stage_mask, 32'd0);
      if (found[AW]) begin
        active_d = found[AW-1:0];
        state_d  = S_START;
      end else begin
        state_d = S_END;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      mask_q       <= '0;
      active_stage <= '0;
      stage_enable <= '0;
      timer        <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_d;
      mask_q       <= mask_d;
      active_stage <= active_d;
      stage_enable <= stage_enable_d;
      timer        <= timer_d;
      busy         <= busy_d;
      frame_done   <= frame_done_d;
      frame_count  <= frame_count_d;
      timeout_err  <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_display_phase_sequencer.sv
// Bench for display_phase_sequencer: directed and random frames checked against a
// frame-level model (stage order, enable lengths, frame latency, counter, sticky error).
module tb_display_phase_sequencer;

  localparam int unsigned NS = 3;
  localparam int unsigned TO = 8;
  localparam int unsigned FW = 2;

  logic          clock = 1'b0;
  logic          reset, enable, continuous, err_clear;
  logic [NS-1:0] stage_mask, stage_done, stage_enable;
  logic [1:0]    active_stage;
  logic          busy, frame_done, timeout_err;
  logic [FW-1:0] frame_count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned dly[NS];
  int unsigned m_fc = 0;
  logic        m_err = 1'b0;

  display_phase_sequencer #(
    .NUM_STAGES(NS), .TIMEOUT_W(24), .TIMEOUT_CYCLES(TO), .FRAME_CNT_W(FW)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .continuous(continuous),
    .stage_mask(stage_mask), .stage_done(stage_done), .err_clear(err_clear),
    .stage_enable(stage_enable), .active_stage(active_stage), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " stage_enable"}, stage_enable, 0);
    check({tag, " active_stage"}, active_stage, 0);
    check({tag, " busy"},         busy,         0);
    check({tag, " frame_done"},   frame_done,   0);
    check({tag, " frame_count"},  frame_count,  0);
    check({tag, " timeout_err"},  timeout_err,  0);
  endtask

  // Acts as the phase engines (done dly[i] RUN cycles after enable, random junk on
  // idle done lines) and checks nfr frames against the frame-level model.
  task automatic run(input int unsigned nfr, input logic [NS-1:0] m, input logic cont,
                     input string tag);
    int unsigned t = 0, seen = 0, cnt = 0, idx = 0, onehot_bad = 0, as_bad = 0;
    int unsigned s_sum = 0, exp_t, nmin;
    logic [NS-1:0] prev = '0;
    logic exp_to = 1'b0;
    int unsigned o_stage[$], o_len[$], fd_t[$], fd_c[$], e_stage[$], e_len[$];
    @(negedge clock);
    stage_mask = m; continuous = cont; enable = 1'b1; stage_done = '0;
    while (seen < nfr && t < 600) begin
      @(negedge clock);
      t++;
      if ($countones(stage_enable) > 1) onehot_bad++;
      if (stage_enable != '0) begin
        for (int unsigned i = 0; i < NS; i++) if (stage_enable[i]) idx = i;
        if (prev == '0) begin o_stage.push_back(idx); cnt = 0; end
        cnt++;
        if (32'(active_stage) != idx) as_bad++;
      end else if (prev != '0) begin
        o_len.push_back(cnt);
      end
      prev = stage_enable;
      if (frame_done) begin
        fd_t.push_back(t); fd_c.push_back(32'(frame_count)); seen++;
      end
      stage_done = NS'($urandom) & ~stage_enable;
      if (stage_enable != '0 && cnt == dly[idx]) stage_done = stage_done | stage_enable;
      if (seen + 1 >= nfr) begin enable = 1'b0; continuous = 1'b0; end
    end
    stage_done = '0; enable = 1'b0; continuous = 1'b0;
    check({tag, " frames seen"}, seen, nfr);
    check({tag, " busy after last frame"}, busy, 0);
    check({tag, " one-hot violations"}, onehot_bad, 0);
    check({tag, " active_stage vs enable"}, as_bad, 0);

    for (int unsigned i = 0; i < NS; i++) begin
      if (m[i]) begin
        s_sum += 2 + ((dly[i] > TO) ? TO : dly[i]);
        if (dly[i] > TO) exp_to = 1'b1;
      end
    end
    for (int unsigned f = 0; f < nfr; f++)
      for (int unsigned i = 0; i < NS; i++)
        if (m[i]) begin
          e_stage.push_back(i);
          e_len.push_back((dly[i] > TO) ? TO : dly[i]);
        end
    check({tag, " activations"}, o_stage.size(), e_stage.size());
    check({tag, " enable pulses"}, o_len.size(), e_len.size());
    nmin = (o_len.size() < e_len.size()) ? o_len.size() : e_len.size();
    for (int unsigned j = 0; j < nmin; j++) begin
      check($sformatf("%s stage[%0d]", tag, j), o_stage[j], e_stage[j]);
      check($sformatf("%s len[%0d]", tag, j), o_len[j], e_len[j]);
    end

    // First frame_done at S+2 negedges after enable is driven; back-to-back frames every S+1.
    exp_t = s_sum + 2;
    for (int unsigned f = 0; f < nfr; f++) begin
      m_fc = (m_fc + 1) % (1 << FW);
      if (f < fd_t.size()) begin
        check($sformatf("%s frame_done time[%0d]", tag, f), fd_t[f], exp_t);
        check($sformatf("%s frame_count[%0d]", tag, f), fd_c[f], m_fc);
      end
      exp_t += s_sum + 1;
    end
    m_err = m_err | exp_to;
    check({tag, " timeout_err"}, timeout_err, m_err);
  endtask

  task automatic clear_err(input string tag);
    @(negedge clock); err_clear = 1'b1;
    @(negedge clock); err_clear = 1'b0;
    m_err = 1'b0;
    check({tag, " timeout_err cleared"}, timeout_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned nfr;
    logic [NS-1:0] m;
    logic cont;
    reset = 1'b1; enable = 1'b0; continuous = 1'b0; err_clear = 1'b0;
    stage_mask = '0; stage_done = '0;
    #12;
    check_zero_outputs("reset");
    @(negedge clock); reset = 1'b0;

    dly = '{4, 4, 4};  run(1, 3'b111, 1'b0, "mask111");
    run(1, 3'b101, 1'b0, "mask101");
    run(1, 3'b000, 1'b0, "mask000");
    dly = '{3, 20, 2}; run(1, 3'b111, 1'b0, "timeout");
    clear_err("timeout");
    dly = '{8, 1, 8};  run(1, 3'b101, 1'b0, "done_at_limit");
    dly = '{9, 1, 1};  run(1, 3'b001, 1'b0, "one_past_limit");
    clear_err("past_limit");
    dly = '{2, 3, 1};  run(5, 3'b011, 1'b1, "continuous");

    for (int unsigned r = 0; r < 14; r++) begin
      m = NS'($urandom);
      for (int unsigned i = 0; i < NS; i++) dly[i] = $urandom_range(1, 11);
      cont = ($urandom_range(0, 2) == 0);
      nfr = cont ? $urandom_range(2, 4) : 1;
      run(nfr, m, cont, $sformatf("rand%0d", r));
      if ($urandom_range(0, 2) == 0) clear_err($sformatf("rand%0d", r));
    end

    // Reset while stage 1 is running: stage 0 finishes at once, stage 1 never does.
    @(negedge clock); stage_mask = 3'b111; enable = 1'b1;
    @(negedge clock); enable = 1'b0;
    for (int unsigned c = 0; c < 40; c++) begin
      stage_done = stage_enable & 3'b001;
      if (stage_enable == 3'b010) break;
      @(negedge clock);
    end
    check("midreset reached stage1", stage_enable, 3'b010);
    #2 reset = 1'b1;
    #1 check_zero_outputs("midreset");
    m_fc = 0; m_err = 1'b0; stage_done = '0;
    @(negedge clock); reset = 1'b0;
    dly = '{3, 3, 3}; run(1, 3'b111, 1'b0, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
